// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-code encoding and small decode helpers.
// Used by the bit-slice ALU, the word-level ALU and the control decoder.
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_XOR  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_RSVD = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_NOR  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    // SUB and SLT both compute a + ~b + cin; only ADD feeds b through unchanged.
    function automatic logic op_inverts_b(input logic [2:0] op);
        return (op == OP_SUB) || (op == OP_SLT);
    endfunction

    // Only the arithmetic ops drive the carry chain; logic ops and the
    // reserved code force cout low so the chain never sees stale carries.
    function automatic logic op_uses_carry(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT);
    endfunction

endpackage

// File: rtl/full_adder_1bit.sv
// Combinational one-bit full adder.
module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic c
);

    assign s = a ^ b ^ cin;
    assign c = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/alu_1bit.sv
// One bit slice of the datapath ALU. Slices chain through cin/cout; result
// and cout are registered, so each slice has one cycle of latency.
module alu_1bit
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic       result,
    output logic       cout,
    input  logic       a,
    input  logic       b,
    input  logic [2:0] op,
    input  logic       cin,
    input  logic       less
);

    logic bb;
    logic fa_s;
    logic fa_c;
    logic result_nxt;
    logic cout_nxt;
    logic result_p1;
    logic cout_p1;

    // Operand B is inverted for subtraction-style ops ahead of the adder.
    assign bb = op_inverts_b(op) ? ~b : b;

    full_adder_1bit u_fa (
        .a   (a),
        .b   (bb),
        .cin (cin),
        .s   (fa_s),
        .c   (fa_c)
    );

    // Op-select mux: picks this slice's result and gates the carry-out.
    always_comb begin
        result_nxt = 1'b0;
        case (op)
            OP_ADD:  result_nxt = fa_s;
            OP_XOR:  result_nxt = a ^ b;
            OP_SUB:  result_nxt = fa_s;
            OP_AND:  result_nxt = a & b;
            OP_OR:   result_nxt = a | b;
            OP_NOR:  result_nxt = ~(a | b);
            OP_SLT:  result_nxt = less;   // adder still runs so the MSB can form the sign
            default: result_nxt = 1'b0;   // reserved code
        endcase
        cout_nxt = op_uses_carry(op) ? fa_c : 1'b0;
    end

    // ---- stage boundary: output register ----
    // Output flops: cleared by reset, otherwise capture the slice function.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_p1 <= 1'b0;
            cout_p1   <= 1'b0;
        end else begin
            result_p1 <= result_nxt;
            cout_p1   <= cout_nxt;
        end
    end

    assign result = result_p1;
    assign cout   = cout_p1;

endmodule

// File: tb/tb_alu_1bit.sv
// Scoreboard bench for alu_1bit: stimulus pushes expected {result,cout},
// a separate monitor pops and compares one cycle later.
module tb_alu_1bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       result;
    logic       cout;
    logic       a;
    logic       b;
    logic [2:0] op;
    logic       cin;
    logic       less;

    logic [1:0] exp_q[$];
    string      name_q[$];
    int         n_cmp  = 0;
    int         n_fail = 0;

    alu_1bit dut (
        .clk    (clk),
        .rst    (rst),
        .result (result),
        .cout   (cout),
        .a      (a),
        .b      (b),
        .op     (op),
        .cin    (cin),
        .less   (less)
    );

    always #5 clk = ~clk;

    // Reference model from the arithmetic definition: {result, cout}.
    function automatic logic [1:0] model(input logic r, input logic ia, input logic ib,
                                         input logic icin, input logic iless,
                                         input logic [2:0] iop);
        int   sum;
        logic bbv;
        logic s;
        logic c;
        if (r) return 2'b00;
        bbv = (iop == 3'b000) ? ib : ~ib;
        sum = int'(ia) + int'(bbv) + int'(icin);
        s   = (sum % 2) == 1;
        c   = sum >= 2;
        case (iop)
            3'b000:  return {s, c};
            3'b001:  return {ia ^ ib, 1'b0};
            3'b010:  return {s, c};
            3'b100:  return {ia & ib, 1'b0};
            3'b101:  return {ia | ib, 1'b0};
            3'b110:  return {~(ia | ib), 1'b0};
            3'b111:  return {iless, c};
            default: return 2'b00;
        endcase
    endfunction

    task automatic drive(input logic r, input logic ia, input logic ib, input logic icin,
                         input logic iless, input logic [2:0] iop,
                         input logic [1:0] exp, input string nm);
        @(negedge clk);
        rst  = r;
        a    = ia;
        b    = ib;
        cin  = icin;
        less = iless;
        op   = iop;
        exp_q.push_back(exp);
        name_q.push_back(nm);
    endtask

    task automatic drive_model(input logic r, input logic ia, input logic ib, input logic icin,
                               input logic iless, input logic [2:0] iop, input string nm);
        drive(r, ia, ib, icin, iless, iop, model(r, ia, ib, icin, iless, iop), nm);
    endtask

    // Monitor: output is valid every cycle, one edge after the inputs.
    initial begin
        logic [1:0] e;
        string      nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                n_cmp++;
                if ({result, cout} !== e) begin
                    n_fail++;
                    $display("FAIL %s: got result=%b cout=%b, expected result=%b cout=%b",
                             nm, result, cout, e[1], e[0]);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; a = 1'b0; b = 1'b0; cin = 1'b0; less = 1'b0; op = 3'b000;

        drive(1'b1, 1, 1, 1, 1, 3'b000, 2'b00, "reset_init");

        // ADD
        drive(1'b0, 1, 1, 0, 0, 3'b000, 2'b01, "add_11");
        drive(1'b0, 0, 0, 0, 0, 3'b000, 2'b00, "add_00");
        // SUB
        drive(1'b0, 1, 0, 0, 0, 3'b010, 2'b01, "sub_10");
        drive(1'b0, 1, 1, 0, 0, 3'b010, 2'b10, "sub_11");
        // SLT
        drive(1'b0, 1, 1, 1, 0, 3'b111, 2'b01, "slt_less0");
        drive(1'b0, 1, 1, 1, 1, 3'b111, 2'b11, "slt_less1");
        // Logic ops and reserved code, a=1 b=0 (cin=1 to prove cout gating)
        drive(1'b0, 1, 0, 1, 0, 3'b001, 2'b10, "xor");
        drive(1'b0, 1, 0, 1, 0, 3'b100, 2'b00, "and");
        drive(1'b0, 1, 0, 1, 0, 3'b101, 2'b10, "or");
        drive(1'b0, 1, 0, 1, 0, 3'b110, 2'b00, "nor");
        drive(1'b0, 1, 1, 1, 1, 3'b011, 2'b00, "rsvd");
        // Reset mid-stream and release
        drive(1'b0, 1, 1, 1, 0, 3'b000, 2'b11, "pre_reset_add");
        drive(1'b1, 1, 1, 1, 0, 3'b000, 2'b00, "reset_mid");
        drive(1'b0, 1, 1, 1, 0, 3'b000, 2'b11, "reset_release");

        // Back-to-back sweep through every op code
        for (int rnd = 0; rnd < 4; rnd++) begin
            for (int o = 0; o < 8; o++) begin
                drive_model(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                            3'(o), "b2b");
            end
        end

        // Randomized traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            drive_model(($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom),
                        1'($urandom), 1'($urandom), 3'($urandom), "rand");
        end

        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
